// File: rtl/uart_cmd_pkg.sv
// Shared constants, types and ASCII/hex helpers for the UART command parser.
package uart_cmd_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;
  localparam logic [7:0] ASCII_L  = 8'h4C;
  localparam logic [7:0] ASCII_QM = 8'h3F;
  localparam logic [7:0] ASCII_O  = 8'h4F;
  localparam logic [7:0] ASCII_K  = 8'h4B;
  localparam logic [7:0] ASCII_E  = 8'h45;
  localparam logic [7:0] ASCII_R  = 8'h52;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARG_HI,
    S_ARG_LO,
    S_TERM_L,
    S_TERM_Q,
    S_DISCARD,
    S_RESP
  } state_t;

  typedef enum logic [1:0] {
    RESP_OK,
    RESP_ER,
    RESP_QUERY
  } resp_sel_t;

  // Element [0] is the first byte sent on the wire.
  typedef logic [3:0][7:0] resp_t;

  function automatic logic is_hex(input logic [7:0] b);
    return ((b >= 8'h30) && (b <= 8'h39)) ||
           ((b >= 8'h41) && (b <= 8'h46)) ||
           ((b >= 8'h61) && (b <= 8'h66));
  endfunction

  // Letters A-F and a-f share low nibbles 1..6, so +9 maps both cases.
  function automatic logic [3:0] hex_to_nib(input logic [7:0] b);
    if (b <= 8'h39) return b[3:0];
    return b[3:0] + 4'd9;
  endfunction

  function automatic logic [7:0] nib_to_hex(input logic [3:0] n);
    if (n < 4'd10) return {4'h3, n};
    return 8'h37 + {4'h0, n};
  endfunction

endpackage

// File: rtl/uart_resp_tx.sv
// Four-byte response serialiser over a valid/ready byte handshake.
module uart_resp_tx
  import uart_cmd_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  resp_t      bytes,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       done
);

  resp_t       resp_buf;
  logic [1:0]  idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_buf <= '0;
      idx      <= 2'd0;
      tx_valid <= 1'b0;
    end else if (load) begin
      resp_buf <= bytes;
      idx      <= 2'd0;
      tx_valid <= 1'b1;
    end else if (tx_valid && tx_ready) begin
      if (idx == 2'd3) tx_valid <= 1'b0;
      else             idx      <= idx + 2'd1;
    end
  end

  assign tx_data = resp_buf[idx];
  assign done    = tx_valid && tx_ready && (idx == 2'd3);

endmodule

// File: rtl/uart_cmd_parser.sv
// ASCII command parser: "Lhh"+T writes the LED register, "?"+T reads it back.
//
//  state     | meaning
//  ----------+---------------------------------------------------------
//  S_IDLE    | waiting for a command letter; bare terminators ignored
//  S_ARG_HI  | 'L' seen, expecting high hex digit
//  S_ARG_LO  | high nibble latched, expecting low hex digit
//  S_TERM_L  | both nibbles latched, expecting terminator
//  S_TERM_Q  | '?' seen, expecting terminator
//  S_DISCARD | malformed line, dropping bytes until terminator
//  S_RESP    | response being sent; rx bytes dropped as overrun
module uart_cmd_parser
  import uart_cmd_pkg::*;
#(
  parameter int LED_WIDTH      = 6,
  parameter int TIMEOUT_CYCLES = 27_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [LED_WIDTH-1:0] led_value,
  output logic                 led_update,
  output logic                 overrun,
  output logic                 busy
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD =
    (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  state_t           state;
  logic [7:0]       arg;
  logic [CNT_W-1:0] cnt;
  logic             is_term;
  logic             timed;
  logic             resp_load;
  resp_sel_t        resp_sel;
  resp_t            resp_bytes;
  logic [7:0]       led_ext;
  logic             tx_done;

  always_comb begin
    is_term   = (rx_data == ASCII_CR) || (rx_data == ASCII_LF);
    timed     = (state != S_IDLE) && (state != S_RESP);
    resp_load = 1'b0;
    resp_sel  = RESP_ER;
    if (rx_valid && is_term) begin
      case (state)
        S_ARG_HI, S_ARG_LO, S_DISCARD: resp_load = 1'b1;
        S_TERM_L: begin
          resp_load = 1'b1;
          resp_sel  = RESP_OK;
        end
        S_TERM_Q: begin
          resp_load = 1'b1;
          resp_sel  = RESP_QUERY;
        end
        default: resp_load = 1'b0;
      endcase
    end
  end

  // Query bytes are built from led_value as it stands when the terminator arrives.
  always_comb begin
    led_ext                 = '0;
    led_ext[LED_WIDTH-1:0]  = led_value;
    case (resp_sel)
      RESP_OK:    resp_bytes = {ASCII_LF, ASCII_CR, ASCII_K, ASCII_O};
      RESP_QUERY: resp_bytes = {ASCII_LF, ASCII_CR, nib_to_hex(led_ext[3:0]),
                                nib_to_hex(led_ext[7:4])};
      default:    resp_bytes = {ASCII_LF, ASCII_CR, ASCII_R, ASCII_E};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      arg        <= 8'h00;
      cnt        <= '0;
      led_value  <= '0;
      led_update <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      led_update <= 1'b0;
      overrun    <= 1'b0;
      if (rx_valid) begin
        cnt <= CNT_LOAD;
        case (state)
          S_IDLE: begin
            if (rx_data == ASCII_L)       state <= S_ARG_HI;
            else if (rx_data == ASCII_QM) state <= S_TERM_Q;
            else if (!is_term)            state <= S_DISCARD;
          end
          S_ARG_HI: begin
            if (is_hex(rx_data)) begin
              arg[7:4] <= hex_to_nib(rx_data);
              state    <= S_ARG_LO;
            end else if (is_term) state <= S_RESP;
            else                  state <= S_DISCARD;
          end
          S_ARG_LO: begin
            if (is_hex(rx_data)) begin
              arg[3:0] <= hex_to_nib(rx_data);
              state    <= S_TERM_L;
            end else if (is_term) state <= S_RESP;
            else                  state <= S_DISCARD;
          end
          S_TERM_L: begin
            if (is_term) begin
              led_value  <= arg[LED_WIDTH-1:0];
              led_update <= 1'b1;
              state      <= S_RESP;
            end else state <= S_DISCARD;
          end
          S_TERM_Q:  state <= is_term ? S_RESP : S_DISCARD;
          S_DISCARD: if (is_term) state <= S_RESP;
          S_RESP:    overrun <= 1'b1;
          default:   state <= S_IDLE;
        endcase
      end else if (timed && (TIMEOUT_CYCLES > 0)) begin
        if (cnt == '0) state <= S_IDLE;
        else           cnt   <= cnt - CNT_W'(1);
      end
      if ((state == S_RESP) && tx_done) state <= S_IDLE;
    end
  end

  assign busy = (state != S_IDLE);

  uart_resp_tx u_resp_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (resp_load),
    .bytes    (resp_bytes),
    .tx_ready (tx_ready),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .done     (tx_done)
  );

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser with a scoreboard of expected tx bytes.
module tb_uart_cmd_parser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [5:0] led_value;
  logic       led_update;
  logic       overrun;
  logic       busy;

  int tests = 0;
  int fails = 0;
  int upd_seen = 0;
  int ovr_seen = 0;
  logic [7:0] exp_q[$];

  uart_cmd_parser #(.LED_WIDTH(6), .TIMEOUT_CYCLES(100)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .led_value  (led_value),
    .led_update (led_update),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transfers happen on the posedge following a negedge with valid&&ready.
  always @(negedge clk) begin
    if (rst_n) begin
      if (led_update) upd_seen++;
      if (overrun) ovr_seen++;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("unexpected_tx", {24'h0, tx_data}, 32'hFFFF_FFFF);
        else                   check("tx_byte", {24'h0, tx_data}, {24'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    @(posedge clk); #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic expect_resp(input logic [7:0] b0, input logic [7:0] b1);
    exp_q.push_back(b0);
    exp_q.push_back(b1);
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && !busy && !tx_valid) break;
    end
    check({tag, "_pending"}, exp_q.size(), 0);
    check({tag, "_busy"}, {31'h0, busy}, 0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_tx_valid", {31'h0, tx_valid}, 0);
    check("rst_tx_data", {24'h0, tx_data}, 0);
    check("rst_led", {26'h0, led_value}, 0);
    check("rst_busy", {31'h0, busy}, 0);
    check("rst_overrun", {31'h0, overrun}, 0);
    rst_n = 1'b1;
    tx_ready = 1'b1;

    // Write 0x2A; tx_valid and led_value change on the edge after the terminator.
    expect_resp(8'h4F, 8'h4B);
    send_str("L2A\n");
    check("l2a_tx_valid_rise", {31'h0, tx_valid}, 1);
    check("l2a_led", {26'h0, led_value}, 32'h2A);
    drain("l2a");
    check("l2a_updates", upd_seen, 1);

    // Upper parsed bits are truncated; bare LF yields nothing.
    expect_resp(8'h4F, 8'h4B);
    send_str("LfF\r");
    drain("lff");
    check("lff_led", {26'h0, led_value}, 32'h3F);
    send_byte(8'h0A);
    repeat (4) @(posedge clk);
    #1;
    check("lf_no_tx", {31'h0, tx_valid}, 0);
    check("lf_busy", {31'h0, busy}, 0);
    expect_resp(8'h33, 8'h46);
    send_str("?\n");
    drain("q3f");

    // Malformed lines.
    expect_resp(8'h45, 8'h52);
    send_str("LG5\n");
    drain("lg5");
    expect_resp(8'h45, 8'h52);
    send_str("X\n");
    drain("x");
    expect_resp(8'h45, 8'h52);
    send_str("L1\n");
    drain("l1");
    check("er_led", {26'h0, led_value}, 32'h3F);
    check("er_updates", upd_seen, 2);

    // Partial command abandoned after 100 idle cycles.
    send_byte(8'h4C);
    repeat (97) @(posedge clk);
    #1;
    check("to_still_busy", {31'h0, busy}, 1);
    repeat (5) @(posedge clk);
    #1;
    check("to_idle", {31'h0, busy}, 0);
    check("to_no_tx", {31'h0, tx_valid}, 0);
    check("to_led", {26'h0, led_value}, 32'h3F);

    expect_resp(8'h4F, 8'h4B);
    send_str("L05\n");
    drain("l05");
    check("l05_led", {26'h0, led_value}, 32'h05);

    // Stall: response held stable, rx byte meanwhile is an overrun.
    tx_ready = 1'b0;
    expect_resp(8'h30, 8'h35);
    send_str("?\n");
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("stall_valid", {31'h0, tx_valid}, 1);
      check("stall_data", {24'h0, tx_data}, 32'h30);
      if (i == 5) begin
        rx_data  = 8'h5A;
        rx_valid = 1'b1;
      end
      if (i == 6) rx_valid = 1'b0;
    end
    check("stall_overrun", ovr_seen, 1);
    check("stall_busy", {31'h0, busy}, 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    drain("stall");

    // Reset while the second response byte is on offer.
    expect_resp(8'h30, 8'h35);
    send_str("?\n");
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 3) break;
    end
    check("mid_first_popped", exp_q.size(), 3);
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mid_rst_tx_valid", {31'h0, tx_valid}, 0);
    check("mid_rst_tx_data", {24'h0, tx_data}, 0);
    check("mid_rst_led", {26'h0, led_value}, 0);
    check("mid_rst_busy", {31'h0, busy}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    expect_resp(8'h30, 8'h30);
    send_str("?\n");
    drain("post_rst");

    check("final_updates", upd_seen, 3);
    check("final_overruns", ovr_seen, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
